// File: rtl/crc_stream_pkg.sv
// Shared CRC definitions: FSM state encoding and parameter presets for common standards.
// Imported by crc_stream and crc_next.
package crc_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // CRC-8 (SMBus)
  localparam logic [7:0]  CRC8_POLY          = 8'h07;
  localparam logic [7:0]  CRC8_INIT          = 8'h00;
  localparam bit          CRC8_REF_IN        = 1'b0;
  localparam bit          CRC8_REF_OUT       = 1'b0;
  localparam logic [7:0]  CRC8_XOR_OUT       = 8'h00;

  // CRC-8/ITU: CRC-8 with a final XOR of 0x55
  localparam logic [7:0]  CRC8_ITU_XOR_OUT   = 8'h55;

  // CRC-8/MAXIM (1-Wire)
  localparam logic [7:0]  CRC8_MAXIM_POLY    = 8'h31;
  localparam logic [7:0]  CRC8_MAXIM_INIT    = 8'h00;
  localparam bit          CRC8_MAXIM_REF_IN  = 1'b1;
  localparam bit          CRC8_MAXIM_REF_OUT = 1'b1;
  localparam logic [7:0]  CRC8_MAXIM_XOR_OUT = 8'h00;

  // CRC-16/CCITT-FALSE
  localparam logic [15:0] CRC16_CCITT_POLY    = 16'h1021;
  localparam logic [15:0] CRC16_CCITT_INIT    = 16'hFFFF;
  localparam bit          CRC16_CCITT_REF_IN  = 1'b0;
  localparam bit          CRC16_CCITT_REF_OUT = 1'b0;
  localparam logic [15:0] CRC16_CCITT_XOR_OUT = 16'h0000;

  // CRC-32 (Ethernet / zlib)
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam bit          CRC32_REF_IN  = 1'b1;
  localparam bit          CRC32_REF_OUT = 1'b1;
  localparam logic [31:0] CRC32_XOR_OUT = 32'hFFFFFFFF;

endpackage

// File: rtl/crc_next.sv
// Combinational CRC next-state: applies DATA_W bit steps to crc_in in message order.
// With DATA_W=1 it degenerates to the single bit step of the bit-serial generator.
module crc_next
  import crc_stream_pkg::*;
#(
  parameter int              WIDTH  = 8,
  parameter int              DATA_W = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(8'h07),
  parameter bit              REF_IN = 1'b0
) (
  input  logic [WIDTH-1:0]  crc_in,
  input  logic [DATA_W-1:0] data,
  output logic [WIDTH-1:0]  crc_out
);

  // Bit reflection only has meaning when the beat is made of whole bytes.
  localparam bit LSB_FIRST = REF_IN && ((DATA_W % 8) == 0);

  logic [DATA_W-1:0] w_bits;
  logic [WIDTH-1:0]  w_chain [DATA_W+1];

  assign w_chain[0] = crc_in;

  // w_bits[i] is the bit consumed at step i; byte k sits at data[DATA_W-1-8k -: 8].
  for (genvar i = 0; i < DATA_W; i++) begin : g_step
    localparam int K   = i / 8;
    localparam int J   = i % 8;
    localparam int IDX = LSB_FIRST ? (DATA_W - 8 - 8 * K + J) : (DATA_W - 1 - i);

    assign w_bits[i] = data[IDX];
    assign w_chain[i+1] = {w_chain[i][WIDTH-2:0], 1'b0}
                        ^ ((w_chain[i][WIDTH-1] ^ w_bits[i]) ? POLY : '0);
  end

  assign crc_out = w_chain[DATA_W];

endmodule

// File: rtl/crc_stream.sv
// Framed streaming CRC: DATA_W bits per clock, result held until consumed.
// Optional CRC_STREAM_CHECK_EN adds exp_crc/out_match for in-line frame checking.
module crc_stream
  import crc_stream_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DATA_W  = 8,
  parameter logic [WIDTH-1:0] POLY    = WIDTH'(8'h07),
  parameter logic [WIDTH-1:0] INIT    = '0,
  parameter bit               REF_IN  = 1'b0,
  parameter bit               REF_OUT = 1'b1,
  parameter logic [WIDTH-1:0] XOR_OUT = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_crc,
`ifdef CRC_STREAM_CHECK_EN
  input  logic [WIDTH-1:0]  exp_crc,
  output logic              out_match,
`endif
  output logic [1:0]        dbg_state
);

  // Handshakes: a beat transfers on in_valid && in_ready, the result on
  // out_valid && out_ready. in_ready follows out_ready while a result is held,
  // so a new frame's first beat can enter on the same edge the old result leaves.

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_crc;
  logic [WIDTH-1:0] r_out_crc;
  logic [WIDTH-1:0] w_crc_base;
  logic [WIDTH-1:0] w_crc_upd;
  logic [WIDTH-1:0] w_refl;
  logic [WIDTH-1:0] w_result;
  logic             w_accept;

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b1;
    out_valid    = 1'b0;
    case (r_state)
      ST_IDLE, ST_ACC: begin
        if (in_valid) w_next_state = in_last ? ST_HOLD : ST_ACC;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) w_next_state = in_last ? ST_HOLD : ST_ACC;
          else          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_accept = in_valid && in_ready;

  // Only a frame already in progress continues from the register; a first beat
  // (from IDLE, or overlapping a retiring result in HOLD) always starts at INIT.
  assign w_crc_base = (r_state == ST_ACC) ? r_crc : INIT;

  crc_next #(
    .WIDTH  (WIDTH),
    .DATA_W (DATA_W),
    .POLY   (POLY),
    .REF_IN (REF_IN)
  ) u_next (
    .crc_in  (w_crc_base),
    .data    (in_data),
    .crc_out (w_crc_upd)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_refl
    assign w_refl[i] = w_crc_upd[WIDTH-1-i];
  end

  assign w_result = (REF_OUT ? w_refl : w_crc_upd) ^ XOR_OUT;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_crc     <= INIT;
      r_out_crc <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_crc <= w_crc_upd;
      end else if ((r_state == ST_HOLD) && out_ready) begin
        r_crc <= INIT;
      end
      if (w_accept && in_last) begin
        r_out_crc <= w_result;
      end
    end
  end

`ifdef CRC_STREAM_CHECK_EN
  logic r_match;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_match <= 1'b0;
    end else if (w_accept && in_last) begin
      r_match <= (w_result == exp_crc);
    end
  end

  assign out_match = r_match;
`endif

  assign out_crc   = r_out_crc;
  assign dbg_state = r_state;

  // A held, unconsumed result must not move.
  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    ((r_state == ST_HOLD) && !out_ready) |=> (r_out_crc == $past(r_out_crc)));

endmodule

// File: tb/tb_crc_stream.sv
// Self-checking bench for crc_stream: seven preset instances driven against a byte-level CRC model.
// Build with CRC_STREAM_CHECK_EN defined to also exercise exp_crc/out_match.
module tb_crc_stream;
  import crc_stream_pkg::*;

  localparam int N = 7;
  // Instance table: 0 CRC-8, 1 CRC-8/MAXIM, 2 CRC-8/ITU, 3/4 CRC-16/CCITT-FALSE, 5/6 CRC-32
  localparam int          CW[N]    = '{8, 8, 8, 16, 16, 32, 32};
  localparam int          CDW[N]   = '{8, 8, 8, 8, 32, 8, 32};
  localparam logic [31:0] CPOLY[N] = '{32'h07, 32'h31, 32'h07, 32'h1021, 32'h1021,
                                       32'h04C11DB7, 32'h04C11DB7};
  localparam logic [31:0] CINIT[N] = '{32'h0, 32'h0, 32'h0, 32'hFFFF, 32'hFFFF,
                                       32'hFFFFFFFF, 32'hFFFFFFFF};
  localparam bit          CRIN[N]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam bit          CROUT[N] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic [31:0] CXOR[N]  = '{32'h0, 32'h0, 32'h55, 32'h0, 32'h0,
                                       32'hFFFFFFFF, 32'hFFFFFFFF};
  // Published check values for "123456789"
  localparam logic [31:0] KNOWN[N] = '{32'hF4, 32'hA1, 32'hA1, 32'h29B1, 32'h0,
                                       32'hCBF43926, 32'h0};

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] in_valid, in_last, out_ready, in_ready, out_valid;
  logic [31:0]  in_data[N];
  logic [N-1:0][1:0] dbg;
  logic [7:0]   oc0, oc1, oc2;
  logic [15:0]  oc3, oc4;
  logic [31:0]  oc5, oc6;
  logic [31:0]  ocrc[N];
`ifdef CRC_STREAM_CHECK_EN
  logic [31:0]  exp_crc[N];
  logic [N-1:0] om;
`endif

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always_comb begin
    ocrc[0] = {24'h0, oc0};
    ocrc[1] = {24'h0, oc1};
    ocrc[2] = {24'h0, oc2};
    ocrc[3] = {16'h0, oc3};
    ocrc[4] = {16'h0, oc4};
    ocrc[5] = oc5;
    ocrc[6] = oc6;
  end

  // ---------------- DUT instances ----------------
  crc_stream #(.WIDTH(8), .DATA_W(8), .POLY(CRC8_POLY), .INIT(CRC8_INIT),
    .REF_IN(CRC8_REF_IN), .REF_OUT(CRC8_REF_OUT), .XOR_OUT(CRC8_XOR_OUT)) u_crc8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0][7:0]), .in_last(in_last[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_crc(oc0),
`ifdef CRC_STREAM_CHECK_EN
    .exp_crc(exp_crc[0][7:0]), .out_match(om[0]),
`endif
    .dbg_state(dbg[0]));

  crc_stream #(.WIDTH(8), .DATA_W(8), .POLY(CRC8_MAXIM_POLY), .INIT(CRC8_MAXIM_INIT),
    .REF_IN(CRC8_MAXIM_REF_IN), .REF_OUT(CRC8_MAXIM_REF_OUT),
    .XOR_OUT(CRC8_MAXIM_XOR_OUT)) u_maxim (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1][7:0]), .in_last(in_last[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_crc(oc1),
`ifdef CRC_STREAM_CHECK_EN
    .exp_crc(exp_crc[1][7:0]), .out_match(om[1]),
`endif
    .dbg_state(dbg[1]));

  crc_stream #(.WIDTH(8), .DATA_W(8), .POLY(CRC8_POLY), .INIT(CRC8_INIT),
    .REF_IN(1'b0), .REF_OUT(1'b0), .XOR_OUT(CRC8_ITU_XOR_OUT)) u_itu (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2][7:0]), .in_last(in_last[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_crc(oc2),
`ifdef CRC_STREAM_CHECK_EN
    .exp_crc(exp_crc[2][7:0]), .out_match(om[2]),
`endif
    .dbg_state(dbg[2]));

  crc_stream #(.WIDTH(16), .DATA_W(8), .POLY(CRC16_CCITT_POLY), .INIT(CRC16_CCITT_INIT),
    .REF_IN(CRC16_CCITT_REF_IN), .REF_OUT(CRC16_CCITT_REF_OUT),
    .XOR_OUT(CRC16_CCITT_XOR_OUT)) u_ccitt8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .in_data(in_data[3][7:0]), .in_last(in_last[3]), .out_valid(out_valid[3]),
    .out_ready(out_ready[3]), .out_crc(oc3),
`ifdef CRC_STREAM_CHECK_EN
    .exp_crc(exp_crc[3][15:0]), .out_match(om[3]),
`endif
    .dbg_state(dbg[3]));

  crc_stream #(.WIDTH(16), .DATA_W(32), .POLY(CRC16_CCITT_POLY), .INIT(CRC16_CCITT_INIT),
    .REF_IN(CRC16_CCITT_REF_IN), .REF_OUT(CRC16_CCITT_REF_OUT),
    .XOR_OUT(CRC16_CCITT_XOR_OUT)) u_ccitt32 (
    .clk(clk), .rst(rst), .in_valid(in_valid[4]), .in_ready(in_ready[4]),
    .in_data(in_data[4]), .in_last(in_last[4]), .out_valid(out_valid[4]),
    .out_ready(out_ready[4]), .out_crc(oc4),
`ifdef CRC_STREAM_CHECK_EN
    .exp_crc(exp_crc[4][15:0]), .out_match(om[4]),
`endif
    .dbg_state(dbg[4]));

  crc_stream #(.WIDTH(32), .DATA_W(8), .POLY(CRC32_POLY), .INIT(CRC32_INIT),
    .REF_IN(CRC32_REF_IN), .REF_OUT(CRC32_REF_OUT), .XOR_OUT(CRC32_XOR_OUT)) u_crc32_8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[5]), .in_ready(in_ready[5]),
    .in_data(in_data[5][7:0]), .in_last(in_last[5]), .out_valid(out_valid[5]),
    .out_ready(out_ready[5]), .out_crc(oc5),
`ifdef CRC_STREAM_CHECK_EN
    .exp_crc(exp_crc[5]), .out_match(om[5]),
`endif
    .dbg_state(dbg[5]));

  crc_stream #(.WIDTH(32), .DATA_W(32), .POLY(CRC32_POLY), .INIT(CRC32_INIT),
    .REF_IN(CRC32_REF_IN), .REF_OUT(CRC32_REF_OUT), .XOR_OUT(CRC32_XOR_OUT)) u_crc32_32 (
    .clk(clk), .rst(rst), .in_valid(in_valid[6]), .in_ready(in_ready[6]),
    .in_data(in_data[6]), .in_last(in_last[6]), .out_valid(out_valid[6]),
    .out_ready(out_ready[6]), .out_crc(oc6),
`ifdef CRC_STREAM_CHECK_EN
    .exp_crc(exp_crc[6]), .out_match(om[6]),
`endif
    .dbg_state(dbg[6]));

  // ---------------- reference model ----------------
  // Message-level CRC: walk the byte list bit by bit, then reflect and XOR.
  function automatic logic [31:0] ref_crc(input int k, input logic [7:0] msg[$]);
    int w;
    logic [31:0] c, r, mask;
    bit b, fb;
    w    = CW[k];
    mask = (w == 32) ? 32'hFFFFFFFF : ((32'd1 << w) - 32'd1);
    c    = CINIT[k];
    foreach (msg[m]) begin
      for (int j = 0; j < 8; j++) begin
        b  = CRIN[k] ? msg[m][j] : msg[m][7-j];
        fb = c[w-1] ^ b;
        c  = ((c << 1) & mask) ^ (fb ? CPOLY[k] : 32'h0);
      end
    end
    if (CROUT[k]) begin
      r = '0;
      for (int i = 0; i < w; i++) r[i] = c[w-1-i];
      c = r;
    end
    return (c ^ CXOR[k]) & mask;
  endfunction

  // ---------------- drivers ----------------
  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic drive_beat(input int k, input logic [31:0] d, input bit last,
                            output bit timed_out);
    int cnt;
    cnt         = 0;
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    in_last[k]  = last;
    #1;
    while (!in_ready[k] && cnt < 50) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    timed_out = !in_ready[k];
    @(negedge clk);
  endtask

  task automatic send_frame(input int k, input logic [7:0] msg[$], input bit gaps,
                            output bit timed_out, output bit early_valid);
    int nb, nbeats;
    logic [31:0] d;
    bit to;
    nb          = CDW[k] / 8;
    nbeats      = msg.size() / nb;
    timed_out   = 1'b0;
    early_valid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      if (gaps) begin
        in_valid[k] = 1'b0;
        in_data[k]  = $urandom;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      d = '0;
      for (int j = 0; j < nb; j++) d = (d << 8) | {24'h0, msg[b*nb+j]};
      if (out_valid[k]) early_valid = 1'b1;
      drive_beat(k, d, (b == nbeats - 1), to);
      if (to) timed_out = 1'b1;
    end
    in_valid[k] = 1'b0;
    in_last[k]  = 1'b0;
  endtask

  task automatic consume(input int k);
    out_ready[k] = 1'b1;
    @(negedge clk);
    out_ready[k] = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < N; k++) begin
      in_valid[k] = 1'b0; in_last[k] = 1'b0; out_ready[k] = 1'b0; in_data[k] = '0;
`ifdef CRC_STREAM_CHECK_EN
      exp_crc[k] = '0;
`endif
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1 || ocrc[k] !== 32'h0 ||
          dbg[k] !== 2'(ST_IDLE)) begin
        errors++;
        $display("FAIL reset inst %0d: out_valid=%b in_ready=%b out_crc=%h state=%0d, want 0 1 0 %0d",
                 k, out_valid[k], in_ready[k], ocrc[k], dbg[k], ST_IDLE);
      end
`ifdef CRC_STREAM_CHECK_EN
      checks++;
      if (om[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_match inst %0d: out_match=%b want 0", k, om[k]);
      end
`endif
    end
  endtask

  task automatic test_known_vectors();
    logic [7:0] q[$];
    logic [31:0] exp;
    bit to, ev;
    int nbytes;
    for (int k = 0; k < N; k++) begin
      q = {};
      nbytes = (CDW[k] == 8) ? 9 : 8;
      for (int i = 0; i < nbytes; i++) q.push_back(8'(8'h31 + i));
      exp = (CDW[k] == 8) ? KNOWN[k] : ref_crc(k, q);
      send_frame(k, q, 1'b0, to, ev);
      checks++;
      if (to || ev) begin
        errors++;
        $display("FAIL known_handshake inst %0d: timeout=%b early_valid=%b want 0 0", k, to, ev);
      end
      checks++;
      if (out_valid[k] !== 1'b1 || dbg[k] !== 2'(ST_HOLD)) begin
        errors++;
        $display("FAIL known_latency inst %0d: out_valid=%b state=%0d want 1 %0d",
                 k, out_valid[k], dbg[k], ST_HOLD);
      end
      checks++;
      if (ocrc[k] !== exp) begin
        errors++;
        $display("FAIL known_crc inst %0d: got %h want %h", k, ocrc[k], exp);
      end
      consume(k);
      checks++;
      if (out_valid[k] !== 1'b0 || ocrc[k] !== exp) begin
        errors++;
        $display("FAIL known_after_consume inst %0d: out_valid=%b out_crc=%h want 0 %h",
                 k, out_valid[k], ocrc[k], exp);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] q1[$], q2[$], q2rest[$], q3[$];
    logic [31:0] exp;
    bit to, ev;
    int len;
    q1 = {};
    for (int i = 0; i < 9; i++) q1.push_back(8'(8'h31 + i));
    send_frame(0, q1, 1'b0, to, ev);
    q2 = {};
    len = $urandom_range(3, 6);
    for (int i = 0; i < len; i++) q2.push_back(8'($urandom));
    in_valid[0] = 1'b1; in_data[0] = {24'h0, q2[0]}; in_last[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1 || ocrc[0] !== 32'hF4) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: in_ready=%b out_valid=%b out_crc=%h want 0 1 f4",
                 c, in_ready[0], out_valid[0], ocrc[0]);
      end
      @(negedge clk);
    end
    out_ready[0] = 1'b1;
    #1;
    checks++;
    if (in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b want 1", in_ready[0]);
    end
    @(negedge clk);
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b0;
    checks++;
    if (out_valid[0] !== 1'b0 || dbg[0] !== 2'(ST_ACC)) begin
      errors++;
      $display("FAIL bp_zero_bubble: out_valid=%b state=%0d want 0 %0d", out_valid[0], dbg[0], ST_ACC);
    end
    q2rest = q2[1:$];
    send_frame(0, q2rest, 1'b1, to, ev);
    exp = ref_crc(0, q2);
    checks++;
    if (to || ev || out_valid[0] !== 1'b1 || ocrc[0] !== exp) begin
      errors++;
      $display("FAIL bp_next_frame: timeout=%b early=%b out_valid=%b out_crc=%h want 0 0 1 %h",
               to, ev, out_valid[0], ocrc[0], exp);
    end
    // Single-beat frame entering on the same edge the previous result retires
    q3 = {};
    q3.push_back(8'($urandom));
    in_valid[0] = 1'b1; in_data[0] = {24'h0, q3[0]}; in_last[0] = 1'b1; out_ready[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0; in_last[0] = 1'b0; out_ready[0] = 1'b0;
    exp = ref_crc(0, q3);
    checks++;
    if (out_valid[0] !== 1'b1 || ocrc[0] !== exp) begin
      errors++;
      $display("FAIL b2b_single_beat: out_valid=%b out_crc=%h want 1 %h", out_valid[0], ocrc[0], exp);
    end
    consume(0);
  endtask

  task automatic test_reset_midframe();
    logic [7:0] q[$];
    bit to, ev;
    for (int b = 0; b < 4; b++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      drive_beat(0, 32'(8'h31 + b), 1'b0, to);
      in_valid[0] = 1'b0;
    end
    checks++;
    if (out_valid[0] !== 1'b0 || dbg[0] !== 2'(ST_ACC)) begin
      errors++;
      $display("FAIL midframe_partial: out_valid=%b state=%0d want 0 %0d", out_valid[0], dbg[0], ST_ACC);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_valid[0] !== 1'b0 || dbg[0] !== 2'(ST_IDLE) || ocrc[0] !== 32'h0 || in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL midframe_reset: out_valid=%b state=%0d out_crc=%h in_ready=%b want 0 %0d 0 1",
               out_valid[0], dbg[0], ocrc[0], in_ready[0], ST_IDLE);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid[0] !== 1'b0) begin
        errors++;
        $display("FAIL midframe_no_result cycle %0d: out_valid=%b want 0", c, out_valid[0]);
      end
    end
    q = {};
    for (int i = 0; i < 9; i++) q.push_back(8'(8'h31 + i));
    send_frame(0, q, 1'b1, to, ev);
    checks++;
    if (to || ev || out_valid[0] !== 1'b1 || ocrc[0] !== 32'hF4) begin
      errors++;
      $display("FAIL midframe_resend: timeout=%b early=%b out_valid=%b out_crc=%h want 0 0 1 f4",
               to, ev, out_valid[0], ocrc[0]);
    end
    consume(0);
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [31:0] exp;
    bit to, ev;
    int k, beats;
    for (int it = 0; it < 12; it++) begin
      k     = $urandom_range(0, N - 1);
      beats = $urandom_range(1, 6);
      q     = {};
      for (int i = 0; i < beats * (CDW[k] / 8); i++) q.push_back(8'($urandom));
      exp = ref_crc(k, q);
      send_frame(k, q, 1'b1, to, ev);
      checks++;
      if (to || ev || out_valid[k] !== 1'b1 || ocrc[k] !== exp) begin
        errors++;
        $display("FAIL random it %0d inst %0d beats %0d: timeout=%b early=%b out_valid=%b out_crc=%h want 0 0 1 %h",
                 it, k, beats, to, ev, out_valid[k], ocrc[k], exp);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      consume(k);
    end
  endtask

`ifdef CRC_STREAM_CHECK_EN
  task automatic test_check();
    logic [7:0] q[$];
    bit to, ev;
    q = {};
    for (int i = 0; i < 9; i++) q.push_back(8'(8'h31 + i));
    exp_crc[0] = 32'hF4;
    send_frame(0, q, 1'b0, to, ev);
    checks++;
    if (om[0] !== 1'b1 || ocrc[0] !== 32'hF4) begin
      errors++;
      $display("FAIL check_match: out_match=%b out_crc=%h want 1 f4", om[0], ocrc[0]);
    end
    consume(0);
    exp_crc[0] = 32'hF5;
    send_frame(0, q, 1'b0, to, ev);
    checks++;
    if (om[0] !== 1'b0 || ocrc[0] !== 32'hF4) begin
      errors++;
      $display("FAIL check_mismatch: out_match=%b out_crc=%h want 0 f4", om[0], ocrc[0]);
    end
    consume(0);
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_known_vectors();
    test_backpressure();
    test_reset_midframe();
    test_random();
`ifdef CRC_STREAM_CHECK_EN
    test_check();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
